// File: rtl/output_neuron.sv
// Output-layer neuron: ANDs each serial activation beat with its weight, sums a frame of
// NUM_IN beats, and presents a thresholded, clamped result. Define OUTPUT_NEURON_ACC_SAT_EN to saturate the sum.
module output_neuron #(
  parameter int NUM_IN = 2,
  parameter int DW     = 4,
  parameter int ACC_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_IN*DW-1:0] w_bus,
  input  logic [ACC_W-1:0]     T,
  output logic [DW-1:0]        outf,
  output logic                 fire,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);
  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'((1 << DW) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    outf_q, outf_d;
  logic             fire_q, fire_d;
  logic             out_valid_q, out_valid_d;

  logic [DW-1:0]    w_arr [NUM_IN];
  logic [DW-1:0]    w_sel;
  logic [ACC_W-1:0] term, acc_base, acc_next, clamped;
  logic             fire_next, beat_acc;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_w
    assign w_arr[gi] = w_bus[gi*DW +: DW];
  end

  assign w_sel    = w_arr[idx_q];
  assign term     = ACC_W'(in_data & w_sel);
  // The first beat of a frame starts from zero regardless of any stale acc value.
  assign acc_base = (idx_q == '0) ? '0 : acc_q;

`ifdef OUTPUT_NEURON_ACC_SAT_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {1'b0, acc_base} + {1'b0, term};
  assign acc_next = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
`else
  assign acc_next = acc_base + term;
`endif

  assign fire_next = (acc_next >= T);
  assign clamped   = (acc_next > OUT_MAX) ? OUT_MAX : acc_next;

  assign in_ready  = reset && (state_q != FIRE);
  assign beat_acc  = in_valid && in_ready;
  assign outf      = outf_q;
  assign fire      = fire_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    outf_d      = outf_q;
    fire_d      = fire_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      state_d     = IDLE;
      acc_d       = '0;
      idx_d       = '0;
      outf_d      = '0;
      fire_d      = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (beat_acc) begin
            acc_d = acc_next;
            if (idx_q == LAST_IDX) begin
              fire_d      = fire_next;
              outf_d      = fire_next ? DW'(clamped) : '0;
              out_valid_d = 1'b1;
              idx_d       = '0;
              state_d     = FIRE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = ACCUM;
            end
          end
        end
        FIRE: begin
          // Result (outf/fire) is left in place after the handshake.
          if (out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      outf_q      <= '0;
      fire_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      outf_q      <= outf_d;
      fire_q      <= fire_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_output_neuron.sv
// Scoreboard bench for output_neuron: three instances (default, 4-bit accumulator, single input)
// driven by directed frames; a negedge monitor compares every presented result against the queue.
module tb_output_neuron;

  typedef struct {
    logic       fire;
    logic [3:0] outf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic out_ready = 1'b1;
  logic [3:0] in_data = '0;

  // instance 0: NUM_IN=2, ACC_W=8
  logic v0 = 1'b0, r0, ov0, f0, b0;
  logic [3:0] o0;
  logic [7:0] w0 = '0, t0 = '0;
  // instance 1: NUM_IN=2, ACC_W=4
  logic v1 = 1'b0, r1, ov1, f1, b1;
  logic [3:0] o1;
  logic [7:0] w1 = 8'hFF;
  logic [3:0] t1 = '0;
  // instance 2: NUM_IN=1, ACC_W=8
  logic v2 = 1'b0, r2, ov2, f2, b2;
  logic [3:0] o2;
  logic [3:0] w2 = 4'hF;
  logic [7:0] t2 = '0;

  int n_checks = 0;
  int n_fail = 0;
  exp_t q0[$], q1[$], q2[$];
  exp_t cur [3];
  bit   seen [3];

  always #5 clk = ~clk;

  output_neuron #(.NUM_IN(2), .DW(4), .ACC_W(8)) u_main (
    .clk(clk), .reset(reset), .clr(clr), .in_data(in_data), .in_valid(v0), .in_ready(r0),
    .w_bus(w0), .T(t0), .outf(o0), .fire(f0), .out_valid(ov0), .out_ready(out_ready), .busy(b0));

  output_neuron #(.NUM_IN(2), .DW(4), .ACC_W(4)) u_w4 (
    .clk(clk), .reset(reset), .clr(clr), .in_data(in_data), .in_valid(v1), .in_ready(r1),
    .w_bus(w1), .T(t1), .outf(o1), .fire(f1), .out_valid(ov1), .out_ready(out_ready), .busy(b1));

  output_neuron #(.NUM_IN(1), .DW(4), .ACC_W(8)) u_one (
    .clk(clk), .reset(reset), .clr(clr), .in_data(in_data), .in_valid(v2), .in_ready(r2),
    .w_bus(w2), .T(t2), .outf(o2), .fire(f2), .out_valid(ov2), .out_ready(out_ready), .busy(b2));

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic logic get_ready(input int which);
    case (which)
      0: return r0;
      1: return r1;
      default: return r2;
    endcase
  endfunction

  function automatic logic get_ov(input int which);
    case (which)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  task automatic set_valid(input int which, input logic v);
    case (which)
      0: v0 = v;
      1: v1 = v;
      default: v2 = v;
    endcase
  endtask

  task automatic push(input int which, input logic f, input logic [3:0] o);
    exp_t e;
    e.fire = f;
    e.outf = o;
    case (which)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // One beat; returns #1 after the accepting edge. For the last beat, checks 1-cycle latency.
  task automatic beat(input int which, input logic [3:0] d, input bit last);
    bit ok = 0;
    @(negedge clk);
    in_data = d;
    set_valid(which, 1'b1);
    for (int k = 0; k < 50; k++) begin
      #1;
      if (get_ready(which)) begin ok = 1; break; end
      @(negedge clk);
    end
    check("beat_accept_timeout", int'(ok), 1);
    @(posedge clk);
    #1 set_valid(which, 1'b0);
    if (last) begin
      @(negedge clk);
      check("out_valid_latency", int'(get_ov(which)), 1);
    end
  endtask

  task automatic wait_drain(input int which);
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!get_ov(which)) begin ok = 1; break; end
    end
    check("drain_timeout", int'(ok), 1);
  endtask

  task automatic mon(input int which, input logic ov, input logic f, input logic [3:0] o);
    exp_t e;
    bit empty;
    if (!ov) begin
      seen[which] = 0;
      return;
    end
    if (!seen[which]) begin
      case (which)
        0: empty = (q0.size() == 0);
        1: empty = (q1.size() == 0);
        default: empty = (q2.size() == 0);
      endcase
      check("unexpected_result", int'(empty), 0);
      if (empty) begin
        seen[which] = 1;
        cur[which].fire = f;
        cur[which].outf = o;
        return;
      end
      case (which)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      cur[which] = e;
      seen[which] = 1;
    end
    check($sformatf("fire_inst%0d", which), int'(f), int'(cur[which].fire));
    check($sformatf("outf_inst%0d", which), int'(o), int'(cur[which].outf));
  endtask

  always @(negedge clk) begin
    mon(0, ov0, f0, o0);
    mon(1, ov1, f1, o1);
    mon(2, ov2, f2, o2);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(ov0), 0);
    check("rst_in_ready", int'(r0), 0);
    check("rst_busy", int'(b0), 0);
    check("rst_fire", int'(f0), 0);
    check("rst_outf", int'(o0), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_in_ready", int'(r0), 1);

    // weighted fire: terms 5&F=5, 6&3=2 -> 7
    w0 = 8'h3F; t0 = 8'd7;
    push(0, 1'b1, 4'h7);
    beat(0, 4'h5, 0); beat(0, 4'h6, 1);
    wait_drain(0);

    // below threshold
    t0 = 8'd8;
    push(0, 1'b0, 4'h0);
    beat(0, 4'h5, 0); beat(0, 4'h6, 1);
    wait_drain(0);

    // clamp + backpressure: 15+15=30 -> outf F
    w0 = 8'hFF; t0 = 8'd20; out_ready = 1'b0;
    push(0, 1'b1, 4'hF);
    beat(0, 4'hF, 0); beat(0, 4'hF, 1);
    t0 = 8'd6;
    push(0, 1'b1, 4'h6);  // next frame 4+2 proves the held beat lands at idx 0
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      in_data = 4'h4; v0 = 1'b1;
      #1 check("bp_in_ready", int'(r0), 0);
      check("bp_busy", int'(b0), 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("hs_in_ready", int'(r0), 0);
    @(negedge clk);
    check("post_hs_out_valid", int'(ov0), 0);
    check("post_hs_in_ready", int'(r0), 1);
    check("post_hs_busy", int'(b0), 0);
    @(posedge clk);
    #1 v0 = 1'b0;
    beat(0, 4'h2, 1);
    wait_drain(0);

    // clr mid-frame drops the 9
    t0 = 8'd2;
    beat(0, 4'h9, 0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr_busy", int'(b0), 0);
    check("clr_out_valid", int'(ov0), 0);
    push(0, 1'b1, 4'h2);
    beat(0, 4'h1, 0); beat(0, 4'h1, 1);
    wait_drain(0);

    // reset mid-frame drops the 9
    beat(0, 4'h9, 0);
    @(negedge clk); reset = 1'b0;
    #1 check("mid_rst_out_valid", int'(ov0), 0);
    check("mid_rst_in_ready", int'(r0), 0);
    check("mid_rst_busy", int'(b0), 0);
    @(negedge clk); reset = 1'b1;
    push(0, 1'b1, 4'h2);
    beat(0, 4'h1, 0); beat(0, 4'h1, 1);
    wait_drain(0);

    // 4-bit accumulator: F+F wraps to E, or saturates to F
    t1 = 4'hE;
`ifdef OUTPUT_NEURON_ACC_SAT_EN
    push(1, 1'b1, 4'hF);
`else
    push(1, 1'b1, 4'hE);
`endif
    beat(1, 4'hF, 0); beat(1, 4'hF, 1);
    wait_drain(1);
    t1 = 4'hF;
`ifdef OUTPUT_NEURON_ACC_SAT_EN
    push(1, 1'b1, 4'hF);
`else
    push(1, 1'b0, 4'h0);
`endif
    beat(1, 4'hF, 0); beat(1, 4'hF, 1);
    wait_drain(1);

    // single-input neuron goes IDLE -> FIRE on one beat
    t2 = 8'd3;
    push(2, 1'b1, 4'h3);
    beat(2, 4'h3, 1);
    wait_drain(2);

    repeat (2) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_neuron.md
Name: output_neuron

Overview:
- Output-layer neuron. Consumes the 4-bit activations produced by upstream input neurons as a serial valid/ready stream, one beat per input.
- Weights each beat by bitwise AND with its per-input weight and accumulates a frame of NUM_IN beats.
- Compares the sum against threshold T and presents one registered result per frame on a valid/ready output handshake.

Parameters:
- NUM_IN, 2, beats (upstream neurons) per frame; legal range 1..16.
- DW, 4, activation/weight/output width.
- ACC_W, 8, accumulator and threshold width; must satisfy ACC_W >= DW.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous frame flush.
- in_data  input  DW  upstream activation for current beat.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- w_bus  input  NUM_IN*DW  weights; beat idx uses w_bus[idx*DW +: DW].
- T  input  ACC_W  firing threshold.
- outf  output  DW  neuron output.
- fire  output  1  threshold met for this frame.
- out_valid  output  1  result held.
- out_ready  input  1  downstream accepts result.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, acc=0, idx=0, outf=0, fire=0, out_valid=0. in_ready=0 while reset is low.
- States:
  - IDLE: no frame in progress. in_ready=1.
  - ACCUM: partial frame held. in_ready=1.
  - FIRE: result presented. in_ready=0, out_valid=1.
- Beat arithmetic: term = in_data & w_bus[idx*DW +: DW], zero-extended to ACC_W. acc_next = (idx==0 ? 0 : acc) + term, modulo 2^ACC_W.
- IDLE + accepted beat:
  - acc<=term, idx<=1, go to ACCUM.
  - If NUM_IN==1, treat the beat as the last beat instead.
- ACCUM + accepted beat, idx<NUM_IN-1: acc<=acc_next, idx++.
- Last beat accepted (idx==NUM_IN-1):
  - fire<=(acc_next >= T), unsigned; T is sampled this cycle only.
  - outf<=fire ? min(acc_next, 2^DW-1) : 0.
  - out_valid<=1, go to FIRE, idx<=0.
- Latency: outf/fire/out_valid are valid on the clock after the last beat is accepted.
- FIRE: outf/fire stay stable until out_valid && out_ready. Then go to IDLE: out_valid<=0, acc<=0; outf and fire keep their values.
- Back-to-back frames: no new beat can be accepted in the out_ready cycle; the next frame starts the following cycle.
- clr, highest priority after reset: next state IDLE, acc=0, idx=0, out_valid=0, fire=0, outf=0. A beat presented in the clr cycle is dropped.
- w_bus is sampled per beat; changes between beats are legal.
- in_valid while in_ready=0 is ignored; upstream holds its beat.
- Reset mid-frame discards the partial accumulation with no output.

Optional Feature:
- Macro: OUTPUT_NEURON_ACC_SAT_EN.
- Defined: accumulation saturates at 2^ACC_W-1 instead of wrapping; the firing compare and outf clamp use the saturated value.
- Undefined: accumulation wraps modulo 2^ACC_W as stated above.

Test Plan:
- Weighted fire: NUM_IN=2, w_bus=8'h3F, T=7, beats 4'h5 then 4'h6 (terms 5, 2).
  - Required: one cycle after the 2nd beat, out_valid=1, fire=1, outf=4'h7, acc=7.
- Below threshold: same stimulus with T=8.
  - Required: fire=0, outf=4'h0, out_valid=1.
- Output clamp + backpressure: w_bus=8'hFF, T=20, beats 4'hF, 4'hF (sum 30); out_ready low for 3 cycles.
  - Required: fire=1, outf=4'hF held stable for 3 cycles.
  - Required: in_ready=0 and an offered beat is not consumed.
  - Required: out_ready=1 gives IDLE next cycle; the beat is accepted as idx 0 of the next frame.
- Flush and reset mid-frame: accept beat 4'h9, then pulse clr; new frame 4'h1, 4'h1 with w_bus=8'hFF, T=2.
  - Required: fire=1, outf=4'h2; the 9 is not included.
  - Repeat with reset low for one cycle instead of clr: same result. out_valid=0 and in_ready=0 during reset.
- Width boundary: ACC_W=4, NUM_IN=2, w_bus=8'hFF, T=4'hE, beats F, F.
  - Without macro: acc wraps to 4'hE, fire=1, outf=4'hE.
  - With OUTPUT_NEURON_ACC_SAT_EN: acc=4'hF, fire=1, outf=4'hF.
  - With T=4'hF: fire=0 without the macro, fire=1 with it.
- NUM_IN=1: single beat 4'h3, w_bus=4'hF, T=3.
  - Required: IDLE straight to FIRE, out_valid next cycle, fire=1, outf=4'h3.
